// File: rtl/sfr_pkg.sv
`default_nettype none
// ============================================================================
// Module : sfr_pkg
// Brief  : Shared types, default sizes and per-bit next-state rule for the
//          special-function-register bank.
// Rev    : 1.0  initial release
// ============================================================================
package sfr_pkg;

    typedef enum logic [1:0] {
        SFR_BIT_RW  = 2'd0,
        SFR_BIT_W1C = 2'd1,
        SFR_BIT_RO  = 2'd2
    } sfr_bit_t;

    localparam int c_SFR_WIDTH     = 32;
    localparam int c_SFR_NUM       = 16;
    localparam int c_SFR_ADDR_W    = 4;
    localparam int c_SFR_IRQ_FLAG  = 0;
    localparam int c_SFR_IRQ_EN    = 1;

    function automatic sfr_bit_t sfr_bit_class(input logic rw, input logic w1c);
        sfr_bit_t cls;
        if (w1c)     cls = SFR_BIT_W1C;
        else if (rw) cls = SFR_BIT_RW;
        else         cls = SFR_BIT_RO;
        return cls;
    endfunction

    // A software write only claims a bit it can actually modify, so a hardware
    // load still lands on RO bits and on W1C bits written with 0.
    function automatic logic sfr_bit_next(
        input sfr_bit_t cls,
        input logic     cur,
        input logic     sw_we,
        input logic     sw_d,
        input logic     hw_we,
        input logic     hw_d,
        input logic     set
    );
        logic nxt;
        nxt = cur;
        if (set)
            nxt = 1'b1;
        else if (sw_we && cls == SFR_BIT_RW)
            nxt = sw_d;
        else if (sw_we && cls == SFR_BIT_W1C && sw_d)
            nxt = 1'b0;
        else if (hw_we && cls != SFR_BIT_RW)
            nxt = hw_d;
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfr_reg.sv
`default_nettype none
// ============================================================================
// Module : sfr_reg
// Brief  : One special-function register with per-bit RW / W1C / RO behaviour.
// Rev    : 1.0  initial release
// ============================================================================
module sfr_reg
    import sfr_pkg::*;
#(
    parameter int               WIDTH    = c_SFR_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter logic [WIDTH-1:0] RW_MASK  = '1,
    parameter logic [WIDTH-1:0] W1C_MASK = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic               i_sw_we,
    input  logic [WIDTH/8-1:0] i_sw_be,
    input  logic [WIDTH-1:0]   i_sw_din,
    input  logic               i_hw_we,
    input  logic [WIDTH-1:0]   i_hw_din,
    input  logic [WIDTH-1:0]   i_hw_set,
    output logic [WIDTH-1:0]   o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        for (int b = 0; b < WIDTH; b++) begin
            w_next[b] = sfr_bit_next(sfr_bit_class(RW_MASK[b], W1C_MASK[b]),
                                     r_q[b], i_sw_we & i_sw_be[b/8], i_sw_din[b],
                                     i_hw_we, i_hw_din[b], i_hw_set[b]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= RST_VAL;
        else if (i_clk_en)
            r_q <= w_next;
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/sfr_bank.sv
`default_nettype none
// ============================================================================
// Module : sfr_bank
// Brief  : Parametrised SFR bank: CPU byte-enabled access, hardware load/set
//          ports, out-of-range error pulse and a registered interrupt.
// Rev    : 1.0  initial release
// ============================================================================
module sfr_bank
    import sfr_pkg::*;
#(
    parameter int SFR_WIDTH    = c_SFR_WIDTH,
    parameter int SFR_NUM      = c_SFR_NUM,
    parameter int ADDR_WIDTH   = c_SFR_ADDR_W,
    parameter logic [SFR_NUM-1:0][SFR_WIDTH-1:0] RST_VAL  = '0,
    parameter logic [SFR_NUM-1:0][SFR_WIDTH-1:0] RW_MASK  = '1,
    parameter logic [SFR_NUM-1:0][SFR_WIDTH-1:0] W1C_MASK = '0,
    parameter int IRQ_FLAG_IDX = c_SFR_IRQ_FLAG,
    parameter int IRQ_EN_IDX   = c_SFR_IRQ_EN
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         sys_clk_en,
    input  logic [ADDR_WIDTH-1:0]        sfr_addr,
    input  logic                         sfr_wen,
    input  logic                         sfr_ren,
    input  logic [SFR_WIDTH/8-1:0]       sfr_be,
    input  logic [SFR_WIDTH-1:0]         sfr_din,
    output logic [SFR_WIDTH-1:0]         sfr_dout,
    output logic                         sfr_err,
    input  logic [SFR_NUM-1:0]           hw_wen,
    input  logic [SFR_NUM*SFR_WIDTH-1:0] hw_din,
    input  logic [SFR_NUM*SFR_WIDTH-1:0] hw_set,
    output logic [SFR_NUM*SFR_WIDTH-1:0] sfr_q,
    output logic                         sfr_irq
);

    // One extra bit so SFR_NUM == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] c_NUM = (ADDR_WIDTH+1)'(SFR_NUM);

    logic [SFR_NUM-1:0][SFR_WIDTH-1:0] w_q;
    logic                              w_addr_ok;
    logic [SFR_WIDTH-1:0]              w_rdata;
    logic [SFR_WIDTH-1:0]              r_dout;
    logic                              r_err;
    logic                              r_irq;

    assign w_addr_ok = ({1'b0, sfr_addr} < c_NUM);

    generate
        for (genvar i = 0; i < SFR_NUM; i++) begin : g_reg
            sfr_reg #(
                .WIDTH    (SFR_WIDTH),
                .RST_VAL  (RST_VAL[i]),
                .RW_MASK  (RW_MASK[i]),
                .W1C_MASK (W1C_MASK[i])
            ) u_reg (
                .i_clk    (sys_clk),
                .i_rst_n  (sys_rst_n),
                .i_clk_en (sys_clk_en),
                .i_sw_we  (sfr_wen && w_addr_ok && (sfr_addr == ADDR_WIDTH'(i))),
                .i_sw_be  (sfr_be),
                .i_sw_din (sfr_din),
                .i_hw_we  (hw_wen[i]),
                .i_hw_din (hw_din[i*SFR_WIDTH +: SFR_WIDTH]),
                .i_hw_set (hw_set[i*SFR_WIDTH +: SFR_WIDTH]),
                .o_q      (w_q[i])
            );
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < SFR_NUM; i++) begin
            if (sfr_addr == ADDR_WIDTH'(i))
                w_rdata = w_q[i];
        end
    end

    // The interrupt samples the register contents settled by the previous edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dout <= '0;
            r_err  <= 1'b0;
            r_irq  <= 1'b0;
        end else if (sys_clk_en) begin
            if (sfr_ren)
                r_dout <= w_addr_ok ? w_rdata : '0;
            r_err <= (sfr_wen || sfr_ren) && !w_addr_ok;
            r_irq <= |(w_q[IRQ_FLAG_IDX] & w_q[IRQ_EN_IDX]);
        end
    end

    assign sfr_q    = w_q;
    assign sfr_dout = r_dout;
    assign sfr_err  = r_err;
    assign sfr_irq  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_sfr_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_sfr_bank
// Brief  : Directed table-driven bench for sfr_bank with hand sequences for
//          reset, set/clear race, interrupt and clock-enable corners.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sfr_bank;

    localparam int W  = 32;
    localparam int N  = 12;
    localparam int AW = 4;
    localparam logic [N*W-1:0] c_RST = {{(N*W-32){1'b0}}, 32'hA5A5_0000} << 96;
    localparam logic [N*W-1:0] c_W1C = {{(N*W-32){1'b0}}, 32'hFFFF_FFFF};
    localparam logic [N*W-1:0] c_RW  = ~({{(N*W-32){1'b0}}, 32'hFFFF_FF00} << 64);

    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic            sys_clk_en;
    logic [AW-1:0]   sfr_addr;
    logic            sfr_wen;
    logic            sfr_ren;
    logic [W/8-1:0]  sfr_be;
    logic [W-1:0]    sfr_din;
    logic [W-1:0]    sfr_dout;
    logic            sfr_err;
    logic [N-1:0]    hw_wen;
    logic [N*W-1:0]  hw_din;
    logic [N*W-1:0]  hw_set;
    logic [N*W-1:0]  sfr_q;
    logic            sfr_irq;

    int n_cmp = 0;
    int n_err = 0;

    sfr_bank #(
        .SFR_WIDTH (W),
        .SFR_NUM   (N),
        .ADDR_WIDTH(AW),
        .RST_VAL   (c_RST),
        .RW_MASK   (c_RW),
        .W1C_MASK  (c_W1C)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sys_clk_en(sys_clk_en),
        .sfr_addr  (sfr_addr),
        .sfr_wen   (sfr_wen),
        .sfr_ren   (sfr_ren),
        .sfr_be    (sfr_be),
        .sfr_din   (sfr_din),
        .sfr_dout  (sfr_dout),
        .sfr_err   (sfr_err),
        .hw_wen    (hw_wen),
        .hw_din    (hw_din),
        .hw_set    (hw_set),
        .sfr_q     (sfr_q),
        .sfr_irq   (sfr_irq)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic          wen;
        logic          ren;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [W-1:0]  din;
        int            ridx;
        logic [W-1:0]  reg_exp;
        logic [W-1:0]  dout_exp;
        logic          err_exp;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [W-1:0] q_of(input int r);
        return sfr_q[r*W +: W];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic cpu(input logic wen, input logic ren, input logic [AW-1:0] addr,
                       input logic [W-1:0] din);
        sfr_wen  = wen;
        sfr_ren  = ren;
        sfr_addr = addr;
        sfr_be   = 4'hF;
        sfr_din  = din;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 4'd3,  4'h0, 32'h0000_0000, 3,  32'hA5A5_0000, 32'hA5A5_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'd2,  4'h3, 32'h1234_5678, 2,  32'h0000_0078, 32'hA5A5_0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'd2,  4'hF, 32'hFFFF_FFFF, 2,  32'h0000_00FF, 32'h0000_0078, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'd3,  4'hA, 32'h1122_3344, 3,  32'h11A5_3300, 32'h0000_0078, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'd13, 4'hF, 32'hFFFF_FFFF, 3,  32'h11A5_3300, 32'h0000_0078, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 4'd0,  4'h0, 32'h0000_0000, 3,  32'h11A5_3300, 32'h0000_0078, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'd14, 4'h0, 32'h0000_0000, 2,  32'h0000_00FF, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 4'd11, 4'hF, 32'hCAFE_F00D, 11, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'd11, 4'h0, 32'h0000_0000, 11, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'd12, 4'hF, 32'h0000_0000, 11, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 4'd0,  4'hF, 32'hFFFF_FFFF, 0,  32'h0000_0000, 32'hCAFE_F00D, 1'b0};

        sys_rst_n = 1'b0; sys_clk_en = 1'b1;
        cpu(1'b0, 1'b0, '0, '0);
        hw_wen = '0; hw_din = '0; hw_set = '0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk) sys_rst_n = 1'b1;

        // Dirty reg3 and sfr_dout, then reset asynchronously mid-cycle.
        cpu(1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF); tick();
        cpu(1'b0, 1'b1, 4'd3, '0);            tick();
        check("pre_rst_dout", sfr_dout, 32'hDEAD_BEEF);
        cpu(1'b0, 1'b0, '0, '0);
        #3 sys_rst_n = 1'b0;
        #1;
        check("rst_reg3", q_of(3), 32'hA5A5_0000);
        check("rst_dout", sfr_dout, '0);
        check("rst_irq", {31'd0, sfr_irq}, '0);
        check("rst_err", {31'd0, sfr_err}, '0);
        @(negedge sys_clk) sys_rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            sfr_wen = vecs[i].wen; sfr_ren = vecs[i].ren; sfr_addr = vecs[i].addr;
            sfr_be  = vecs[i].be;  sfr_din = vecs[i].din;
            tick();
            check($sformatf("vec%0d_reg%0d", i, vecs[i].ridx), q_of(vecs[i].ridx), vecs[i].reg_exp);
            check($sformatf("vec%0d_dout", i), sfr_dout, vecs[i].dout_exp);
            check($sformatf("vec%0d_err", i), {31'd0, sfr_err}, {31'd0, vecs[i].err_exp});
        end
        check("oor_reg2_intact", q_of(2), 32'h0000_00FF);

        // Hardware set must beat a simultaneous software clear.
        cpu(1'b1, 1'b0, 4'd0, 32'h10); hw_set[4] = 1'b1; tick();
        check("race_set_wins", q_of(0), 32'h0000_0010);
        hw_set = '0; tick();
        check("race_clear", q_of(0), 32'h0000_0000);

        cpu(1'b0, 1'b0, '0, '0);
        hw_wen[2] = 1'b1; hw_din[2*W +: W] = 32'hFFFF_0000;
        hw_wen[0] = 1'b1; hw_din[0 +: W]   = 32'h0000_0005;
        tick();
        check("hwload_reg2", q_of(2), 32'hFFFF_00FF);
        check("hwload_reg0", q_of(0), 32'h0000_0005);
        hw_wen = '0; hw_din = '0;
        cpu(1'b1, 1'b0, 4'd0, 32'hFFFF_FFFF); tick();
        check("w1c_all", q_of(0), 32'h0000_0000);

        cpu(1'b1, 1'b0, 4'd1, 32'h10); tick();
        check("irq_en_reg1", q_of(1), 32'h0000_0010);
        check("irq_idle", {31'd0, sfr_irq}, '0);
        cpu(1'b0, 1'b0, '0, '0); hw_set[4] = 1'b1; tick();
        hw_set = '0;
        check("irq_flag_set", q_of(0), 32'h0000_0010);
        check("irq_not_yet", {31'd0, sfr_irq}, '0);
        tick();
        check("irq_asserted", {31'd0, sfr_irq}, 32'd1);
        cpu(1'b1, 1'b0, 4'd0, 32'h10); tick();
        check("irq_flag_clr", q_of(0), 32'h0000_0000);
        check("irq_still_hi", {31'd0, sfr_irq}, 32'd1);
        cpu(1'b0, 1'b0, '0, '0); tick();
        check("irq_dropped", {31'd0, sfr_irq}, '0);

        // Arm irq and err, then freeze everything with the clock enable.
        hw_set[4] = 1'b1; tick();
        hw_set = '0; cpu(1'b1, 1'b0, 4'd15, '0); tick();
        check("ce_pre_err", {31'd0, sfr_err}, 32'd1);
        check("ce_pre_irq", {31'd0, sfr_irq}, 32'd1);
        sys_clk_en = 1'b0;
        cpu(1'b1, 1'b1, 4'd0, 32'hFFFF_FFFF);
        hw_set[W] = 1'b1; hw_wen[2] = 1'b1;
        repeat (3) tick();
        check("ce_reg0", q_of(0), 32'h0000_0010);
        check("ce_reg1", q_of(1), 32'h0000_0010);
        check("ce_reg2", q_of(2), 32'hFFFF_00FF);
        check("ce_reg3", q_of(3), 32'h11A5_3300);
        check("ce_dout", sfr_dout, 32'hCAFE_F00D);
        check("ce_err", {31'd0, sfr_err}, 32'd1);
        check("ce_irq", {31'd0, sfr_irq}, 32'd1);

        sys_clk_en = 1'b1; tick();
        check("ce_on_reg0", q_of(0), 32'h0000_0000);
        check("ce_on_reg1", q_of(1), 32'h0000_0011);
        check("ce_on_reg2", q_of(2), 32'h0000_00FF);
        check("ce_on_dout", sfr_dout, 32'h0000_0010);
        check("ce_on_err", {31'd0, sfr_err}, '0);
        check("ce_on_irq", {31'd0, sfr_irq}, 32'd1);
        cpu(1'b0, 1'b0, '0, '0); hw_set = '0; hw_wen = '0; tick();
        check("ce_on_irq_low", {31'd0, sfr_irq}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
